intersection_arbiter: RTL and testbench
=======================================

# intersection_arbiter

Round-robin phase scheduler for a multi-approach signalised intersection. It shares one green phase among up to four approaches, each of which has its own red/yellow/green head. Phase timing is counted in seconds from an external 1 Hz tick, so the block sits downstream of the pulse generator. It sits upstream of the lamp drivers, and approach requests come from push-buttons or vehicle detectors.

## Interface
- N_APP, 4 — number of approaches, legal range 2..4.
- T_MIN_GREEN, 10 — minimum green time, in ticks.
- T_MAX_GREEN, 60 — green cap in ticks; used only when SEMAFOR_MAX_GREEN_EN is defined.
- T_YELLOW, 5 — yellow duration, in ticks.
- T_ALL_RED, 2 — all-red clearance time, in ticks.
- CW, 7 — width of the phase counter; every T_* parameter must lie in 1..2^CW-1.
- clk in 1 — system clock.
- rst in 1 — reset, asynchronous, active-low.
- tick in 1 — one-clk-wide pulse, once per second.
- req in N_APP — level request per approach (button or detector).
- green out N_APP — green lamp per approach.
- yellow out N_APP — yellow lamp per approach.
- red out N_APP — red lamp per approach.
- grant_idx out 2 — index of the approach owning the current green/yellow phase.
- grant_vld out 1 — high during GREEN and YELLOW.

## Operation
- **Request capture.** A sticky register `pend[N_APP]` records requests.
  - On every clk, `pend[i]` is set by `req[i]`.
  - A request from the current owner is ignored while that owner is in GREEN or YELLOW.
  - `pend[owner]` clears on the clk where the block enters GREEN.
- **States.** ALL_RED, GREEN, YELLOW. All state changes and counter updates occur only on clk edges where `tick=1`.
- **ALL_RED.**
  - On a tick with `cnt < T_ALL_RED-1`: increment `cnt`.
  - Otherwise, if any `pend` bit is set: choose the owner round-robin, searching from `ptr+1` upward with wrap. Then set `ptr` = owner and `grant_idx` = owner, move to GREEN, and set `cnt` = 0.
  - Otherwise the block parks in ALL_RED with `cnt` held, and grants on the first tick that sees a `pend` bit.
- **GREEN.**
  - `cnt` increments on each tick and saturates at 2^CW-1.
  - Depart condition `D`: `cnt >= T_MIN_GREEN-1` and at least one `pend[j]` is set for some `j != owner`.
  - When `D` holds on a tick: move to YELLOW and set `cnt` = 0.
  - With no competing request, green rests indefinitely.
- **YELLOW.** On the tick where `cnt == T_YELLOW-1`, move to ALL_RED and set `cnt` = 0.
- **Outputs.** Outputs are registered. For every approach, exactly one of `red`, `yellow`, `green` is 1 at all times.
  - Non-owners are always red.
  - The owner shows green in GREEN and yellow in YELLOW.
- **Reset values.**
  - Outputs: `red` all 1s, `green` = 0, `yellow` = 0, `grant_idx` = 0, `grant_vld` = 0.
  - Internal: state ALL_RED, `cnt` = 0, `pend` = 0, `ptr` = N_APP-1, so the first grant searches from approach 0.
- **Reset mid-phase.** Reset forces the all-red reset values immediately; no yellow phase is run.
- **Simultaneous events.**
  - A `req` arriving on a depart tick is already visible in `pend` on the next clk. It cannot change the current decision.
  - `req[i]` set on the same clk that `pend[i]` is cleared by its grant is dropped; the approach is being served.

## Timing
- `req` to `pend`: 1 clk.
- Decisions are evaluated on tick clks; lamp outputs change on that same edge.
- Phase lengths in ticks:
  - yellow = T_YELLOW exactly;
  - all-red ≥ T_ALL_RED;
  - green ≥ T_MIN_GREEN.
- Worst-case wait for a pending approach, with default timings: (N_APP-1) × (green + T_YELLOW + T_ALL_RED).
- `tick` held high for several clks is illegal input and is not guarded against.

## Configuration
- **SEMAFOR_MAX_GREEN_EN defined.** Green extension is enabled while the owner's raw `req` stays high. `D` becomes true when both of these hold:
  - a competing `pend` bit is set; and
  - either `cnt >= T_MIN_GREEN-1` with `req[owner]=0` (gap-out), or `cnt >= T_MAX_GREEN-1` (max-out, regardless of `req[owner]`).
- **Not defined.** `D` is as in Operation, `T_MAX_GREEN` is unused, and `req[owner]` has no effect during GREEN.

## Structure
- Package `semafor_pkg` holds:
  - the `phase_t` enum (ALL_RED, GREEN, YELLOW);
  - the default timing constants;
  - `APP_IDX_W` = 2.
- Sub-module `rr_picker`: combinational round-robin priority picker.
  - Inputs: `pend`, `ptr`.
  - Outputs: `idx` and `any`.
  - It is reusable by other arbiters in the codebase.

## Test plan
Parameters for all scenarios: T_MIN_GREEN=3, T_YELLOW=2, T_ALL_RED=1, N_APP=4, tick every 4 clks.

1. **Reset.** Assert reset during GREEN → `red`=4'b1111, `green`=0, `yellow`=0, `grant_vld`=0 immediately. After release with no `req`, the block stays all-red.
2. **Single request.** One-clk pulse on `req[2]` → `green[2]` on the first tick after the 1-tick clearance has elapsed. Green rests indefinitely with no other requests.
3. **Minimum green.** Approach 0 is green and `req[1]` pulses at green tick 0 → green for 3 ticks, `yellow[0]` for 2 ticks, all-red 1 tick, then `green[1]`.
4. **Round-robin order.**
   - Owner 1; `req[0]` and `req[3]` pending → next grant is 3, then 0.
   - Both pending from reset → grant order 0, then 3.
5. **Owner request ignored.** Hold `req[owner]` during green → `pend[owner]` stays 0; no re-grant after yellow unless others are idle and `req` is re-asserted in ALL_RED.
6. **With SEMAFOR_MAX_GREEN_EN, T_MAX_GREEN=6.**
   - Owner `req` held high with a competitor pending → yellow after exactly 6 green ticks.
   - Owner `req` low → yellow after 3 green ticks.

Source files
------------

// File: rtl/semafor_pkg.sv
// Shared types and default timing for the intersection phase scheduler.
// Optional feature macro used by the top: SEMAFOR_MAX_GREEN_EN.
package semafor_pkg;

    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        GREEN   = 2'd1,
        YELLOW  = 2'd2
    } phase_t;

    localparam int unsigned DEF_N_APP       = 4;
    localparam int unsigned DEF_T_MIN_GREEN = 10;
    localparam int unsigned DEF_T_MAX_GREEN = 60;
    localparam int unsigned DEF_T_YELLOW    = 5;
    localparam int unsigned DEF_T_ALL_RED   = 2;
    localparam int unsigned DEF_CW          = 7;

    localparam int unsigned APP_IDX_W = 2;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: returns the first set bit of pend
// searching upward from ptr+1 with wrap-around; any flags a non-empty set.
module rr_picker
    import semafor_pkg::*;
#(
    parameter int unsigned N_APP = DEF_N_APP
) (
    input  logic [N_APP-1:0]     pend,
    input  logic [APP_IDX_W-1:0] ptr,
    output logic [APP_IDX_W-1:0] idx,
    output logic                 any
);

    logic [APP_IDX_W-1:0] cand;

    // Scan ptr+1 .. ptr+N_APP (mod N_APP); the first hit wins.
    always_comb begin
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int unsigned k = 1; k <= N_APP; k++) begin
            cand = APP_IDX_W'((32'(ptr) + k) % N_APP);
            if (!any && pend[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intersection_arbiter.sv
// Round-robin green-phase scheduler for up to four approaches.
// Phase timing advances only on 1 Hz tick clocks; lamp outputs are registered.
// Define SEMAFOR_MAX_GREEN_EN to enable green extension with a T_MAX_GREEN cap.
module intersection_arbiter
    import semafor_pkg::*;
#(
    parameter int unsigned N_APP       = DEF_N_APP,
    parameter int unsigned T_MIN_GREEN = DEF_T_MIN_GREEN,
    parameter int unsigned T_MAX_GREEN = DEF_T_MAX_GREEN,
    parameter int unsigned T_YELLOW    = DEF_T_YELLOW,
    parameter int unsigned T_ALL_RED   = DEF_T_ALL_RED,
    parameter int unsigned CW          = DEF_CW
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic [N_APP-1:0]     req,
    output logic [N_APP-1:0]     green,
    output logic [N_APP-1:0]     yellow,
    output logic [N_APP-1:0]     red,
    output logic [APP_IDX_W-1:0] grant_idx,
    output logic                 grant_vld
);

    localparam logic [CW-1:0]    MIN_G_M1 = CW'(T_MIN_GREEN - 1);
    localparam logic [CW-1:0]    YEL_M1   = CW'(T_YELLOW - 1);
    localparam logic [CW-1:0]    AR_M1    = CW'(T_ALL_RED - 1);
    localparam logic [N_APP-1:0] ONE      = N_APP'(1);
`ifdef SEMAFOR_MAX_GREEN_EN
    localparam logic [CW-1:0]    MAX_G_M1 = CW'(T_MAX_GREEN - 1);
`endif

    phase_t               state, state_nxt;
    logic [CW-1:0]        cnt, cnt_nxt;
    logic [N_APP-1:0]     pend, pend_nxt;
    logic [APP_IDX_W-1:0] ptr, ptr_nxt;
    logic [APP_IDX_W-1:0] idx_nxt;
    logic [N_APP-1:0]     green_nxt, yellow_nxt, red_nxt;
    logic                 vld_nxt;

    logic [APP_IDX_W-1:0] pick_idx;
    logic                 pick_any;
    logic [N_APP-1:0]     owner_mask;
    logic                 serving;
    logic                 competitor;
    logic                 depart;

    rr_picker #(
        .N_APP (N_APP)
    ) u_picker (
        .pend (pend),
        .ptr  (ptr),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // Owner identity and the green departure condition.
    always_comb begin
        owner_mask = ONE << grant_idx;
        serving    = (state == GREEN) || (state == YELLOW);
        competitor = |(pend & ~owner_mask);
`ifdef SEMAFOR_MAX_GREEN_EN
        depart = competitor &&
                 (((cnt >= MIN_G_M1) && !(|(req & owner_mask))) || (cnt >= MAX_G_M1));
`else
        depart = competitor && (cnt >= MIN_G_M1);
`endif
    end

    // Next-state, counter, request capture and registered-lamp computation.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        ptr_nxt   = ptr;
        idx_nxt   = grant_idx;
        pend_nxt  = pend | (serving ? (req & ~owner_mask) : req);

        if (tick) begin
            case (state)
                ALL_RED: begin
                    if (cnt < AR_M1) begin
                        cnt_nxt = cnt + 1'b1;
                    end else if (pick_any) begin
                        state_nxt = GREEN;
                        cnt_nxt   = '0;
                        ptr_nxt   = pick_idx;
                        idx_nxt   = pick_idx;
                        // The winner's own req on this clk is dropped with its pend bit.
                        pend_nxt  = pend_nxt & ~(ONE << pick_idx);
                    end
                end
                GREEN: begin
                    if (depart) begin
                        state_nxt = YELLOW;
                        cnt_nxt   = '0;
                    end else if (cnt != '1) begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                YELLOW: begin
                    if (cnt == YEL_M1) begin
                        state_nxt = ALL_RED;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                default: begin
                    state_nxt = ALL_RED;
                    cnt_nxt   = '0;
                end
            endcase
        end

        // Lamps are derived from the next phase so they change on the deciding edge.
        green_nxt  = '0;
        yellow_nxt = '0;
        for (int unsigned i = 0; i < N_APP; i++) begin
            green_nxt[i]  = (state_nxt == GREEN)  && (idx_nxt == APP_IDX_W'(i));
            yellow_nxt[i] = (state_nxt == YELLOW) && (idx_nxt == APP_IDX_W'(i));
        end
        red_nxt = ~(green_nxt | yellow_nxt);
        vld_nxt = (state_nxt != ALL_RED);
    end

    // State and output registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ALL_RED;
            cnt       <= '0;
            pend      <= '0;
            ptr       <= APP_IDX_W'(N_APP - 1);
            grant_idx <= '0;
            grant_vld <= 1'b0;
            green     <= '0;
            yellow    <= '0;
            red       <= '1;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            pend      <= pend_nxt;
            ptr       <= ptr_nxt;
            grant_idx <= idx_nxt;
            grant_vld <= vld_nxt;
            green     <= green_nxt;
            yellow    <= yellow_nxt;
            red       <= red_nxt;
        end
    end

endmodule

// File: tb/tb_intersection_arbiter.sv
// Scoreboard bench for intersection_arbiter: a phase-duration reference model
// pushes the expected lamp state each clock; a monitor pops and compares.
module tb_intersection_arbiter;

    localparam int N    = 4;
    localparam int TMIN = 3;
    localparam int TMAX = 6;
    localparam int TY   = 2;
    localparam int TAR  = 1;
    localparam int NCYC = 3200;

    typedef struct packed {
        logic [3:0] g;
        logic [3:0] y;
        logic [3:0] r;
        logic [1:0] idx;
        logic       vld;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       tick;
    logic [3:0] req;
    logic [3:0] green, yellow, red;
    logic [1:0] grant_idx;
    logic       grant_vld;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    bit   done  = 0;
    int   cyc   = 0;

    // Reference model: phase 0 = all red, 1 = green, 2 = yellow.
    int m_phase;
    int m_elapsed;   // ticks spent in the current phase so far
    int m_last;      // most recently served approach (search origin)
    int m_shown;     // approach reported on grant_idx
    bit m_pend[N];

    intersection_arbiter #(
        .N_APP       (N),
        .T_MIN_GREEN (TMIN),
        .T_MAX_GREEN (TMAX),
        .T_YELLOW    (TY),
        .T_ALL_RED   (TAR),
        .CW          (7)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tick      (tick),
        .req       (req),
        .green     (green),
        .yellow    (yellow),
        .red       (red),
        .grant_idx (grant_idx),
        .grant_vld (grant_vld)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_phase   = 0;
        m_elapsed = 0;
        m_last    = N - 1;
        m_shown   = 0;
        for (int j = 0; j < N; j++) m_pend[j] = 0;
    endtask

    task automatic model_edge(input logic [3:0] r, input logic t);
        int  e;
        int  old_owner;
        bit  was_serving;
        bit  comp;
        bit  any;
        bit  granted;
        int  winner;
        bit  dep;
        old_owner   = m_shown;
        was_serving = (m_phase != 0);
        comp = 0;
        any  = 0;
        for (int j = 0; j < N; j++) begin
            if (m_pend[j]) any = 1;
            if (m_pend[j] && j != old_owner) comp = 1;
        end
        granted = 0;
        winner  = 0;
        if (t) begin
            e = m_elapsed + 1;
            if (m_phase == 0) begin
                if (e >= TAR && any) begin
                    for (int k = N; k >= 1; k--)
                        if (m_pend[(m_last + k) % N]) winner = (m_last + k) % N;
                    granted   = 1;
                    m_phase   = 1;
                    m_elapsed = 0;
                    m_last    = winner;
                    m_shown   = winner;
                end else begin
                    m_elapsed = e;
                end
            end else if (m_phase == 1) begin
`ifdef SEMAFOR_MAX_GREEN_EN
                dep = comp && ((e >= TMIN && !r[old_owner]) || e >= TMAX);
`else
                dep = comp && (e >= TMIN);
`endif
                if (dep) begin
                    m_phase   = 2;
                    m_elapsed = 0;
                end else begin
                    m_elapsed = e;
                end
            end else begin
                if (e == TY) begin
                    m_phase   = 0;
                    m_elapsed = 0;
                end else begin
                    m_elapsed = e;
                end
            end
        end
        for (int j = 0; j < N; j++)
            if (r[j] && !(was_serving && j == old_owner)) m_pend[j] = 1;
        if (granted) m_pend[winner] = 0;
    endtask

    function automatic exp_t model_out();
        exp_t x;
        x.g = '0;
        x.y = '0;
        for (int i = 0; i < N; i++) begin
            if (m_shown == i && m_phase == 1) x.g[i] = 1'b1;
            if (m_shown == i && m_phase == 2) x.y[i] = 1'b1;
        end
        x.r   = ~(x.g | x.y);
        x.idx = 2'(m_shown);
        x.vld = (m_phase != 0);
        return x;
    endfunction

    // Stimulus: drive inputs just after each rising edge, advance the model
    // for the edge that just happened, then push the expected outputs.
    initial begin
        logic [3:0] nreq;
        logic       nrst;
        rst  = 1'b0;
        req  = '0;
        tick = 1'b0;
        model_reset();
        for (int c = 0; c < NCYC; c++) begin
            @(posedge clk);
            if (rst) model_edge(req, tick);
            #1;
            cyc  = c;
            nrst = 1'b1;
            nreq = '0;
            if (c < 3) begin
                nrst = 1'b0;
            end else if (c < 200) begin
                if (c == 10) nreq = 4'b0100;
            end else if (c < 800) begin
                if ($urandom_range(15) == 0) nreq = 4'b0001 << $urandom_range(3);
            end else if (c < 1300) begin
                nreq = 4'b0001 << m_shown;
                if ($urandom_range(40) == 0) nreq = nreq | (4'b0001 << $urandom_range(3));
            end else if (c < 1304) begin
                nrst = 1'b0;
            end else if (c < 2400) begin
                nreq = 4'($urandom) & 4'($urandom);
            end else if (c < 2404) begin
                nrst = 1'b0;
            end else if (c < 2700) begin
                if (c == 2410) nreq = 4'b1001;
            end else begin
                if ($urandom_range(7) == 0) nreq = 4'($urandom);
                if ($urandom_range(300) == 0) nrst = 1'b0;
            end
            rst  = nrst;
            req  = nreq;
            tick = ((c % 4) == 0);
            if (!rst) model_reset();
            sb.push_back(model_out());
        end
        done = 1;
        repeat (2) @(negedge clk);
        #1;
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL sb_drain: leftover=%0d want=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Monitor: outputs are presented every clock; compare on the falling edge.
    initial begin
        exp_t want;
        exp_t got;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                want = sb.pop_front();
                got  = {green, yellow, red, grant_idx, grant_vld};
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL lamps cyc=%0d got g=%b y=%b r=%b idx=%0d vld=%b want g=%b y=%b r=%b idx=%0d vld=%b",
                             cyc, got.g, got.y, got.r, got.idx, got.vld,
                             want.g, want.y, want.r, want.idx, want.vld);
                end
                for (int i = 0; i < N; i++) begin
                    total++;
                    if ((int'(green[i]) + int'(yellow[i]) + int'(red[i])) != 1) begin
                        bad++;
                        $display("FAIL onehot cyc=%0d app=%0d got g=%b y=%b r=%b want exactly one lamp",
                                 cyc, i, green[i], yellow[i], red[i]);
                    end
                end
            end else if (!done) begin
                total++;
                bad++;
                $display("FAIL sb_underflow cyc=%0d got empty queue want an entry", cyc);
            end
        end
    end

endmodule
